// File: rtl/heap_pq_pkg.sv
// Shared types and index helpers for the heap priority-queue controller.
// Index helpers work in 32 bits; callers size-cast to their own index width.
package heap_pq_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP_RD,
    S_UP_CMP,
    S_DN_RD,
    S_DN_CMP,
    S_DONE
  } state_t;

  function automatic int unsigned parent_idx(input int unsigned i);
    return (i - 1) >> 1;
  endfunction

  function automatic int unsigned left_idx(input int unsigned i);
    return 2 * i + 1;
  endfunction

  function automatic int unsigned right_idx(input int unsigned i);
    return 2 * i + 2;
  endfunction

endpackage

// File: rtl/heap_pq_ram.sv
// Heap storage: DEPTH x DW, two synchronous read ports and one write port.
// Reads return the pre-write contents when addresses collide; the controller never depends on bypass.
module heap_pq_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic [DW-1:0] rd_data0,
  output logic [DW-1:0] rd_data1,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data0 <= mem[rd_addr0];
    rd_data1 <= mem[rd_addr1];
  end

endmodule

// File: rtl/heap_pq_ctrl.sv
// Clocked max-heap priority queue: sift-up on push, sift-down on pop, one level per compare step.
// Define HEAP_PEEK_EN to add peek_valid/peek_data, a registered shadow of the root.
module heap_pq_ctrl
  import heap_pq_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  input  logic          pop_valid,
  output logic          pop_ready,
  output logic          pop_data_valid,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          busy
`ifdef HEAP_PEEK_EN
  ,
  output logic          peek_valid,
  output logic [DW-1:0] peek_data
`endif
);

  state_t        state_reg, state_next;
  logic [DW-1:0] cur_reg, cur_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [AW:0]   n_reg, n_next;
  logic [AW:0]   count_reg, count_next;
  logic          pop_pend_reg, pop_pend_next;
  logic [DW-1:0] pop_hold_reg;

  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr;
  logic [DW-1:0] rd_data0, rd_data1, wr_data;
  logic          wr_en;

  logic          idle, empty_w, full_w;
  logic [AW:0]   cnt_m1;
  logic [AW-1:0] par_w;
  logic [AW:0]   left_w, right_w;
  logic          left_ok, right_ok, pick_right;
  logic [DW-1:0] child_val;
  logic [AW:0]   child_idx;

  heap_pq_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  assign idle    = (state_reg == S_IDLE);
  assign empty_w = (count_reg == '0);
  assign full_w  = (count_reg == (AW+1)'(DEPTH));
  assign cnt_m1  = count_reg - 1'b1;

  // Pop wins over push; both are masked while reset is held.
  assign pop_ready  = idle && !empty_w && !rst;
  assign push_ready = idle && !full_w && !pop_valid && !rst;

  assign count = count_reg;
  assign empty = empty_w;
  assign full  = full_w;
  assign busy  = !idle;

  // Root read in the acceptance cycle appears on rd_data0 during the following cycle.
  assign pop_data_valid = pop_pend_reg;
  assign pop_data       = pop_pend_reg ? rd_data0 : pop_hold_reg;

  // Child indices need AW+1 bits: at the deepest level 2*idx+2 exceeds the RAM address range.
  assign par_w     = AW'(parent_idx(32'(idx_reg)));
  assign left_w    = (AW+1)'(left_idx(32'(idx_reg)));
  assign right_w   = (AW+1)'(right_idx(32'(idx_reg)));
  assign left_ok   = (left_w < n_reg);
  assign right_ok  = (right_w < n_reg);
  assign pick_right = right_ok && (rd_data1 > rd_data0);
  assign child_val = pick_right ? rd_data1 : rd_data0;
  assign child_idx = pick_right ? right_w : left_w;

  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    idx_next      = idx_reg;
    n_next        = n_reg;
    count_next    = count_reg;
    pop_pend_next = 1'b0;
    rd_addr0      = '0;
    rd_addr1      = '0;
    wr_en         = 1'b0;
    wr_addr       = idx_reg;
    wr_data       = cur_reg;

    case (state_reg)
      S_IDLE: begin
        if (pop_valid && pop_ready) begin
          count_next    = cnt_m1;
          rd_addr0      = '0;
          rd_addr1      = cnt_m1[AW-1:0];
          pop_pend_next = 1'b1;
          idx_next      = '0;
          n_next        = cnt_m1;
          state_next    = (count_reg == (AW+1)'(1)) ? S_DONE : S_DN_RD;
        end else if (push_valid && push_ready) begin
          count_next = count_reg + 1'b1;
          cur_next   = push_data;
          idx_next   = count_reg[AW-1:0];
          if (empty_w) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_data    = push_data;
            state_next = S_DONE;
          end else begin
            state_next = S_UP_RD;
          end
        end
      end

      S_UP_RD: begin
        if (idx_reg == '0) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          wr_data    = cur_reg;
          state_next = S_DONE;
        end else begin
          rd_addr0   = par_w;
          state_next = S_UP_CMP;
        end
      end

      S_UP_CMP: begin
        wr_en = 1'b1;
        if (cur_reg > rd_data0) begin
          wr_data    = rd_data0;
          idx_next   = par_w;
          state_next = S_UP_RD;
        end else begin
          state_next = S_DONE;
        end
      end

      S_DN_RD: begin
        rd_addr0 = left_w[AW-1:0];
        rd_addr1 = right_w[AW-1:0];
        // First pass after a pop: the last element is on rd_data1 and becomes the sifting key.
        if (pop_pend_reg) begin
          cur_next = rd_data1;
        end
        state_next = S_DN_CMP;
      end

      S_DN_CMP: begin
        wr_en = 1'b1;
        if (!left_ok || (child_val <= cur_reg)) begin
          state_next = S_DONE;
        end else begin
          wr_data    = child_val;
          idx_next   = child_idx[AW-1:0];
          state_next = S_DN_RD;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cur_reg      <= '0;
      idx_reg      <= '0;
      n_reg        <= '0;
      count_reg    <= '0;
      pop_pend_reg <= 1'b0;
      pop_hold_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      idx_reg      <= idx_next;
      n_reg        <= n_next;
      count_reg    <= count_next;
      pop_pend_reg <= pop_pend_next;
      if (pop_pend_reg) begin
        pop_hold_reg <= rd_data0;
      end
    end
  end

`ifdef HEAP_PEEK_EN
  logic [DW-1:0] peek_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      peek_reg <= '0;
    end else if (wr_en && (wr_addr == '0)) begin
      peek_reg <= wr_data;
    end
  end

  assign peek_valid = !empty_w && idle;
  assign peek_data  = peek_reg;
`endif

endmodule
